// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, MEM-branch flush and MDU occupancy.
// Optional stall/flush performance counters are enabled with `define HAZARD_PERF_EN.
module hazard_ctrl #(
    parameter int unsigned MDU_LAT = 4,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned PERF_W  = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [4:0]        id_rs_i,
    input  logic [4:0]        id_rt_i,
    input  logic              id_use_rt_i,
    input  logic              ex_mem_read_i,
    input  logic [4:0]        ex_rt_i,
    input  logic              mdu_start_i,
    input  logic              branch_i,
`ifdef HAZARD_PERF_EN
    output logic [PERF_W-1:0] stall_cnt_o,
    output logic [PERF_W-1:0] flush_cnt_o,
`endif
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_write_o,
    output logic              idex_flush_o,
    output logic              exmem_flush_o,
    output logic              mdu_busy_o,
    output logic              mdu_done_o
);

    typedef enum logic [0:0] {
        StRun,
        StBusy
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_use;

    if (MDU_LAT < 2 || MDU_LAT > (1 << CNT_W) || PERF_W < 1) begin : g_param_check
        $error("hazard_ctrl: illegal parameter combination");
    end

    // $0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign load_use = ex_mem_read_i && (ex_rt_i != 5'd0) &&
                      ((ex_rt_i == id_rs_i) || (id_use_rt_i && (ex_rt_i == id_rt_i)));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= StRun;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        pc_write_o    = 1'b1;
        ifid_write_o  = 1'b1;
        ifid_flush_o  = 1'b0;
        idex_write_o  = 1'b1;
        idex_flush_o  = 1'b0;
        exmem_flush_o = 1'b0;
        mdu_busy_o    = 1'b0;
        mdu_done_o    = 1'b0;

        // While reset is held the outputs stay at their idle values regardless of inputs.
        if (rst_i) begin
            unique case (state_q)
                StRun: begin
                    if (branch_i) begin
                        ifid_flush_o  = 1'b1;
                        idex_flush_o  = 1'b1;
                        exmem_flush_o = 1'b1;
                    end else if (mdu_start_i) begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_write_o  = 1'b0;
                        exmem_flush_o = 1'b1;
                        // Start cycle counts as the first of MDU_LAT; BUSY covers the rest.
                        cnt_d         = CNT_W'(MDU_LAT - 2);
                        state_d       = StBusy;
                    end else if (load_use) begin
                        pc_write_o    = 1'b0;
                        ifid_write_o  = 1'b0;
                        idex_flush_o  = 1'b1;
                    end
                end
                StBusy: begin
                    mdu_busy_o    = 1'b1;
                    pc_write_o    = 1'b0;
                    ifid_write_o  = 1'b0;
                    idex_write_o  = 1'b0;
                    exmem_flush_o = 1'b1;
                    if (cnt_q == '0) begin
                        mdu_done_o = 1'b1;
                        state_d    = StRun;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_d = StRun;
                end
            endcase
        end
    end

`ifdef HAZARD_PERF_EN
    logic [PERF_W-1:0] stall_cnt_q, flush_cnt_q;
    logic              stall_inc, flush_inc;

    assign stall_inc = !pc_write_o;
    assign flush_inc = rst_i && (state_q == StRun) && branch_i;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + PERF_W'(1);
            end
            if (flush_inc && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + PERF_W'(1);
            end
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage CPU. It drives the program counter's write enable and the write/flush controls of the IF/ID, ID/EX and EX/MEM registers. It resolves three hazard classes:
- load-use data hazards, by a 1-cycle stall plus bubble;
- taken branches resolved in MEM, by flushing the younger stages;
- multi-cycle multiply/divide occupancy of EX, via a counter-based FSM.

Parameters:
MDU_LAT, 4, total cycles a mult/div instruction occupies EX; legal range 2..(2^CNT_W).
CNT_W, 3, width of the MDU occupancy down-counter.
PERF_W, 32, width of the performance counters (used only with the optional feature).

Ports:
clk_i  input  1  clock; all state updates on rising edge
rst_i  input  1  asynchronous active-low reset
id_rs_i  input  5  rs field of the instruction in ID
id_rt_i  input  5  rt field of the instruction in ID
id_use_rt_i  input  1  instruction in ID reads rt as a source
ex_mem_read_i  input  1  instruction in EX is a load
ex_rt_i  input  5  destination register of the load in EX
mdu_start_i  input  1  instruction in EX is a mult/div; valid only in RUN
branch_i  input  1  branch resolved taken in MEM this cycle
pc_write_o  output  1  PC write enable (1 = load next PC)
ifid_write_o  output  1  IF/ID write enable
ifid_flush_o  output  1  IF/ID flush (insert NOP)
idex_write_o  output  1  ID/EX write enable
idex_flush_o  output  1  ID/EX flush (bubble)
exmem_flush_o  output  1  EX/MEM flush (bubble)
mdu_busy_o  output  1  FSM in BUSY
mdu_done_o  output  1  1-cycle pulse: last EX cycle of the mult/div

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=RUN, cnt=0.
  - Outputs forced: pc_write_o=1, ifid_write_o=1, idex_write_o=1; all flushes=0; mdu_busy_o=0, mdu_done_o=0.
  - Reset mid-BUSY abandons the operation immediately; no mdu_done_o pulse.
- Outputs are combinational from state plus current inputs (Mealy) and take effect on the same clock edge.
- Load-use condition LU = ex_mem_read_i && ex_rt_i!=0 && (ex_rt_i==id_rs_i || (id_use_rt_i && ex_rt_i==id_rt_i)).
- State RUN, evaluated in priority order:
  1. branch_i=1:
     - ifid_flush_o=1, idex_flush_o=1, exmem_flush_o=1, pc_write_o=1.
     - LU and mdu_start_i are ignored (the offending instructions are flushed).
     - Remain in RUN.
  2. mdu_start_i=1:
     - pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_flush_o=1.
     - cnt<=MDU_LAT-2; next state BUSY.
     - LU is not evaluated this cycle.
  3. LU=1:
     - pc_write_o=0, ifid_write_o=0, idex_flush_o=1.
     - Exactly 1 bubble; remain in RUN.
  4. Otherwise: all write enables=1, all flushes=0.
- State BUSY:
  - Outputs: mdu_busy_o=1, pc_write_o=0, ifid_write_o=0, idex_write_o=0, exmem_flush_o=1.
  - cnt>0: cnt<=cnt-1.
  - cnt==0: mdu_done_o=1; next state RUN. Enables stay deasserted this cycle; the pipeline resumes on the following cycle.
  - branch_i and mdu_start_i are ignored in BUSY; the bench flags branch_i=1 in BUSY as a protocol error.
- Total EX occupancy for one mult/div is exactly MDU_LAT cycles: the start cycle in RUN plus MDU_LAT-1 cycles in BUSY.
- No wrap-around: cnt never decrements below 0.
- A load-use condition present on the cycle after BUSY exits is handled normally in RUN.
- Register $0 is never a hazard source.

Optional Feature:
Macro HAZARD_PERF_EN.
- Defined:
  - Adds output ports stall_cnt_o [PERF_W-1:0] and flush_cnt_o [PERF_W-1:0], reset to 0.
  - stall_cnt_o increments every cycle pc_write_o=0.
  - flush_cnt_o increments every cycle branch_i causes a flush.
  - Both counters saturate at all-ones and do not wrap.
- Not defined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Load-use: ex_mem_read_i=1, ex_rt_i=5, id_rs_i=5 for 1 cycle -> pc_write_o=0, ifid_write_o=0, idex_flush_o=1 that cycle only; next cycle all enables=1.
- $0 and rt-use gating: ex_mem_read_i=1, ex_rt_i=0, id_rs_i=0 -> no stall. Then ex_rt_i=7, id_rt_i=7, id_use_rt_i=0 -> no stall; id_use_rt_i=1 -> stall.
- MDU with MDU_LAT=4: mdu_start_i pulse at cycle T -> pc_write_o=0 for cycles T..T+3; mdu_busy_o=1 for T+1..T+3; mdu_done_o=1 only at T+3; pc_write_o=1 at T+4.
- Priority: branch_i=1 together with mdu_start_i=1 and LU=1 -> all three flushes=1, pc_write_o=1, mdu_busy_o stays 0 next cycle.
- Async reset mid-BUSY: assert rst_i=0 at T+2 (between clock edges) -> outputs immediately at reset values, mdu_busy_o=0; after release, normal RUN with no mdu_done_o pulse.
- HAZARD_PERF_EN: 1 load-use plus 1 MDU (MDU_LAT=4) plus 2 taken branches -> stall_cnt_o=5, flush_cnt_o=2; preload near all-ones -> counter holds at saturation.
